// File: rtl/alu_exec_unit.sv
// ALU execute unit: ALUOp/funct decode, 1-cycle logic/arith ops,
// iterative MUL (shift-add) and DIVU (restoring), valid/ready both sides.
// Ports:
//   clk, reset                   clock and sync active-high reset
//   in_valid/in_ready            request handshake
//   alu_op, funct, a, b          request payload
//   out_valid/out_ready          result handshake
//   result, zero, illegal, busy  registered result and status
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_NOR, OP_SLT, OP_MUL, OP_DIV, OP_ILL
  } op_t;

  state_t state, state_n;
  op_t    op;

  logic             accept;
  logic             multi;
  logic [FUNCT_W-1:0] f_hi;
  logic [WIDTH-1:0] alu_res;

  // acc: product or remainder; x: multiplicand or
  // dividend/quotient shift reg; y: multiplier or divisor
  logic [WIDTH-1:0] acc, x, y;
  logic [WIDTH-1:0] acc_n, x_n, y_n;
  logic [WIDTH-1:0] fin;
  logic [WIDTH:0]   rsh, diff;
  logic [CW-1:0]    cnt;
  logic             is_div;

  always_comb begin
    f_hi = funct >> 6;
    op   = OP_ILL;
    unique case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        if (f_hi == '0) begin
          unique case (funct[5:0])
            6'h20:   op = OP_ADD;
            6'h22:   op = OP_SUB;
            6'h24:   op = OP_AND;
            6'h25:   op = OP_OR;
            6'h26:   op = OP_XOR;
            6'h27:   op = OP_NOR;
            6'h2A:   op = OP_SLT;
            6'h18:   op = OP_MUL;
            6'h1B:   op = OP_DIV;
            default: op = OP_ILL;
          endcase
        end
      end
      default: op = OP_ILL;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          $signed(a) < $signed(b)};
      default: alu_res = '0;
    endcase
  end

  assign multi    = (op == OP_MUL) || (op == OP_DIV);
  assign in_ready = !reset &&
                    (state == IDLE ||
                     (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;

  // One iteration step; divide-by-zero naturally
  // yields an all-ones quotient since rsh >= 0.
  always_comb begin
    acc_n = acc;
    x_n   = x;
    y_n   = y;
    rsh   = {acc, x[WIDTH-1]};
    diff  = rsh - {1'b0, y};
    if (is_div) begin
      if (rsh >= {1'b0, y}) begin
        acc_n = diff[WIDTH-1:0];
        x_n   = {x[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = rsh[WIDTH-1:0];
        x_n   = {x[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = y[0] ? acc + x : acc;
      x_n   = x << 1;
      y_n   = y >> 1;
    end
    fin = is_div ? x_n : acc_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = multi ? ITER : DONE;
      ITER: if (cnt == CW'(1)) state_n = DONE;
      DONE: begin
        if (accept)         state_n = multi ? ITER : DONE;
        else if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      acc     <= '0;
      x       <= '0;
      y       <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
    end else if (accept) begin
      if (multi) begin
        cnt    <= CW'(WIDTH);
        is_div <= (op == OP_DIV);
        acc    <= '0;
        x      <= a;
        y      <= b;
      end else begin
        result  <= alu_res;
        zero    <= (alu_res == '0);
        illegal <= (op == OP_ILL);
      end
    end else if (state == ITER) begin
      acc <= acc_n;
      x   <= x_n;
      y   <= y_n;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        result  <= fin;
        zero    <= (fin == '0);
        illegal <= 1'b0;
      end
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with an
// expected-result queue filled on accept.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  logic         busy;

  int tests = 0;
  int fails = 0;
  logic [W:0] q[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .FUNCT_W(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero),
    .illegal(illegal), .busy(busy)
  );

  function automatic logic [W:0] model(
    input logic [1:0] op, input logic [5:0] f,
    input logic [W-1:0] p, input logic [W-1:0] r);
    logic [W-1:0] v;
    logic         ill;
    v   = '0;
    ill = 1'b0;
    if (op == 2'b00)      v = p + r;
    else if (op == 2'b01) v = p - r;
    else if (op == 2'b11) ill = 1'b1;
    else begin
      case (f)
        6'h20: v = p + r;
        6'h22: v = p - r;
        6'h24: v = p & r;
        6'h25: v = p | r;
        6'h26: v = p ^ r;
        6'h27: v = ~(p | r);
        6'h2A: v = ($signed(p) < $signed(r)) ? 1 : 0;
        6'h18: v = p * r;
        6'h1B: v = (r == 0) ? '1 : p / r;
        default: ill = 1'b1;
      endcase
    end
    return {ill, v};
  endfunction

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [W:0] e;
    tests++;
    assert (q.size() != 0) else begin
      fails++;
      $error("FAIL %s_q obs=empty exp=entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_res"}, result, e[W-1:0]);
      chk({tag, "_ill"}, W'(illegal), W'(e[W]));
      chk({tag, "_zero"}, W'(zero),
          W'(e[W-1:0] == '0));
    end
  endtask

  task automatic send(input logic [1:0] op,
                      input logic [5:0] f,
                      input logic [W-1:0] p,
                      input logic [W-1:0] r);
    alu_op   = op;
    funct    = f;
    a        = p;
    b        = r;
    in_valid = 1'b1;
    #1;
    chk("in_ready", W'(in_ready), W'(1));
    q.push_back(model(op, f, p, r));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alu_op   = 2'($urandom);
    funct    = 6'($urandom);
  endtask

  task automatic wait_out(input string tag,
                          input int elat);
    int   n;
    logic bad;
    n   = 1;
    bad = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) bad = 1'b1;
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, W'(n), W'(elat));
    chk({tag, "_rdy"}, W'(bad), W'(0));
    pop_chk(tag);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_drop"}, W'(out_valid), W'(0));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = '0;
    funct     = '0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",  W'(in_ready),  W'(0));
    chk("rst_ov",   W'(out_valid), W'(0));
    chk("rst_busy", W'(busy),      W'(0));
    chk("rst_res",  result,        W'(0));
    chk("rst_ill",  W'(illegal),   W'(0));
    reset = 1'b0;

    send(2'b10, 6'h20, 32'h5, 32'h3);
    wait_out("add", 1);
    send(2'b01, 6'h00, 32'h1234, 32'h1234);
    wait_out("sub", 1);
    send(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1);
    wait_out("slt_neg", 1);
    send(2'b10, 6'h2A, 32'h1, 32'hFFFF_FFFF);
    wait_out("slt_pos", 1);
    send(2'b10, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00);
    wait_out("and", 1);
    send(2'b10, 6'h25, 32'hF000_0001, 32'h0000_1230);
    wait_out("or", 1);
    send(2'b10, 6'h26, 32'hAAAA_5555, 32'hFFFF_0000);
    wait_out("xor", 1);
    send(2'b10, 6'h27, 32'h0F0F_0000, 32'h0000_00F0);
    wait_out("nor", 1);
    send(2'b00, 6'h3F, 32'hFFFF_FFFF, 32'h1);
    wait_out("add_wrap", 1);

    send(2'b10, 6'h18, 32'h0001_0003, 32'h7);
    wait_out("mul", 33);
    send(2'b10, 6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out("mul_wrap", 33);
    send(2'b10, 6'h1B, 32'd100, 32'd7);
    wait_out("divu", 33);
    send(2'b10, 6'h1B, 32'd5, 32'd0);
    wait_out("divu0", 33);
    send(2'b10, 6'h1B, 32'hFFFF_FFFF, 32'h10);
    wait_out("divu_big", 33);

    send(2'b11, 6'h20, 32'h5, 32'h5);
    wait_out("ill_op", 1);
    send(2'b10, 6'h3F, 32'h5, 32'h5);
    wait_out("ill_fn", 1);

    out_ready = 1'b0;
    send(2'b10, 6'h20, 32'h10, 32'h20);
    wait_out("hold_first", 1);
    alu_op   = 2'b10;
    funct    = 6'h20;
    a        = 32'h100;
    b        = 32'h1;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_res", result,         W'(32'h30));
      chk("hold_ov",  W'(out_valid), W'(1));
      chk("hold_rdy", W'(in_ready),  W'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_rdy0", W'(in_ready), W'(1));
    q.push_back(model(alu_op, funct, a, b));
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      chk("b2b_ov", W'(out_valid), W'(1));
      pop_chk("b2b");
      a = W'(i * 3);
      b = W'(i + 100);
      chk("b2b_rdy", W'(in_ready), W'(1));
      q.push_back(model(alu_op, funct, a, b));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b_ov", W'(out_valid), W'(1));
    pop_chk("b2b_last");
    @(posedge clk); #1;
    chk("b2b_drop", W'(out_valid), W'(0));

    send(2'b10, 6'h18, 32'h1234, 32'h5678);
    void'(q.pop_back());
    repeat (9) @(posedge clk);
    #1;
    chk("mr_busy_pre", W'(busy), W'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mr_busy", W'(busy),      W'(0));
    chk("mr_ov",   W'(out_valid), W'(0));
    chk("mr_res",  result,        W'(0));
    chk("mr_zero", W'(zero),      W'(0));
    chk("mr_ill",  W'(illegal),   W'(0));
    chk("mr_rdy",  W'(in_ready),  W'(0));
    reset = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mr_never", W'(seen), W'(0));
    send(2'b10, 6'h20, 32'd7, 32'd8);
    wait_out("post_rst", 1);
    chk("q_empty", W'(q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
